fmdsp_pipe_mult: RTL
====================

// Module: fmdsp_pipe_mult
// PURPOSE
//  Parametrised, pipelined successor to the fracturable DSP multiplier model.
//  Computes a signed product in one of four precision/accumulate modes, with
//  valid tracking and an initiation-interval (II) issue guard. Sits behind the
//  operand-select logic; its out_valid strobe drives the result comparators.
// PARAMETERS
//  N          9  width of operand aa (full precision)
//  M          9  width of operand bb (full precision)
//  A_LO       5  low-precision width of aa (A_LO <= N)
//  B_LO       5  low-precision width of bb (B_LO <= M)
//  PIPES      1  extra output register stages after the product stage (>= 0)
//  II         4  minimum cycles between accepted starts (>= 1)
//  ACC_GUARD  4  accumulator guard bits; OUT_W = N+M+ACC_GUARD
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      issue request; accepted only when ready=1
//  mode       in   2      00 lo*lo, 01 lo*full, 10 full*full, 11 full*full accumulate
//  acc_clr    in   1      mode 11 only: accumulate from zero instead of acc
//  aa         in   N      operand A, two's complement
//  bb         in   M      operand B, two's complement
//  ready      out  1      issue slot open (II counter at zero)
//  drop_err   out  1      one-cycle pulse: start seen while ready=0
//  out_valid  out  1      one-cycle pulse per accepted start, aligned with out
//  out        out  OUT_W  signed result, sign-extended to OUT_W
// BEHAVIOUR
//  - Reset (async assert, sync release): all pipeline regs, acc, out = 0;
//    out_valid=0, drop_err=0, ready=1, II counter=0.
//  - Accept = start & ready. On accept: aa, bb, mode, acc_clr captured in
//    stage-0 regs; II counter loads II-1. Counter decrements to 0 each cycle;
//    ready = (counter==0). With II=1, ready stays 1 (back-to-back issue).
//  - start & !ready: request discarded, drop_err=1 next cycle, no state change.
//  - Stage 1 (product): from stage-0 regs only, never live inputs:
//    00: $signed(aa[A_LO-1:0]) * $signed(bb[B_LO-1:0])
//    01: $signed(aa[A_LO-1:0]) * $signed(bb[M-1:0])
//    10: $signed(aa) * $signed(bb)
//    11: sum = (acc_clr ? 0 : acc) + full product; acc <= sum; result = sum.
//    Every product is sign-extended to OUT_W. Accumulation wraps modulo
//    2^OUT_W, no saturation. acc changes only on valid mode-11 stage-1 beats.
//  - Valid bit travels with data; stage regs load only when their valid is
//    set, so out holds the last result between pulses.
//  - Latency: accept at edge k -> out_valid=1 and out valid in the cycle after
//    edge k+1+PIPES (PIPES=1: 3rd edge incl. capture). Fully pipelined, no stall.
//  - Mode changes between issues are legal; each beat uses its own captured mode.
//  - Reset mid-operation flushes all in-flight beats: no out_valid after
//    release until a new accept; acc returns to 0.
// TESTING  (N=M=9, A_LO=B_LO=5, PIPES=1, II=4, OUT_W=22)
//  1 mode 00, aa=9'h01F, bb=9'h003 -> out=22'h3FFFFD (-3), out_valid 3 edges later
//  2 mode 01, aa=9'h010, bb=9'h0FF -> out=22'h3FF010 (-16*255=-4080)
//  3 mode 10, aa=9'h100, bb=9'h100 -> out=22'h010000 (+65536, widest corner)
//  4 mode 11: acc_clr=1 aa=3 bb=4 -> 22'h00000C; then acc_clr=0 aa=5 bb=5 -> 22'h000025
//  5 start at t and t+2 -> second dropped, drop_err pulse, exactly one out_valid;
//    start at t+4 accepted
//  6 rst pulse 1 cycle after accept -> no out_valid afterward, ready=1, acc=0

Source files
------------

// File: rtl/fmdsp_pipe_mult.sv
// fmdsp_pipe_mult: pipelined signed multiplier with four modes.
// The four modes are lo*lo, lo*full, full*full and full*full accumulate.
// Issue is guarded by an initiation-interval counter. Every result leaves
// the pipe with a one-cycle valid strobe.
module fmdsp_pipe_mult #(
  parameter int N         = 9,
  parameter int M         = 9,
  parameter int A_LO      = 5,
  parameter int B_LO      = 5,
  parameter int PIPES     = 1,
  parameter int II        = 4,
  parameter int ACC_GUARD = 4,
  localparam int OUT_W    = N + M + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  input  logic [N-1:0]     aa,
  input  logic [M-1:0]     bb,
  output logic             ready,
  output logic             drop_err,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);

  typedef enum logic [1:0] {
    MODE_LO_LO     = 2'b00,
    MODE_LO_FULL   = 2'b01,
    MODE_FULL_FULL = 2'b10,
    MODE_ACC       = 2'b11
  } mode_e;

  // The counter is kept at least one bit wide so that II=1 still elaborates.
  localparam int CNT_W = (II > 1) ? $clog2(II) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(II - 1);

  logic [CNT_W-1:0] ii_cnt;
  logic             accept;

  // Stage 0 holds the captured operands and command.
  logic             s0_valid;
  logic [N-1:0]     s0_aa;
  logic [M-1:0]     s0_bb;
  mode_e            s0_mode;
  logic             s0_clr;

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] prod;
  logic [OUT_W-1:0] result;

  // Index 0 is the product stage. Indices 1..PIPES are extra output registers.
  logic             pipe_valid [0:PIPES];
  logic [OUT_W-1:0] pipe_data  [0:PIPES];

  assign ready  = (ii_cnt == '0);
  assign accept = start & ready;

  // Issue guard: reload on accept, then count down to zero.
  // The drop pulse flags a start request that arrived while the slot was closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ii_cnt   <= '0;
      drop_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values and simulation ordering cannot
      // change the result.
      drop_err <= start & ~ready;
      if (accept)
        ii_cnt <= CNT_LOAD;
      else if (ii_cnt != '0)
        ii_cnt <= ii_cnt - 1'b1;
    end
  end

  // Stage 0 captures the operands and command only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_aa    <= '0;
      s0_bb    <= '0;
      s0_mode  <= MODE_LO_LO;
      s0_clr   <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_aa   <= aa;
        s0_bb   <= bb;
        s0_mode <= mode_e'(mode);
        s0_clr  <= acc_clr;
      end
    end
  end

  // The product is formed from stage-0 registers only.
  // Each operand is sign-extended to the output width before the multiply.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    prod   = '0;
    result = '0;
    unique case (s0_mode)
      MODE_LO_LO:
        prod = OUT_W'($signed(s0_aa[A_LO-1:0])) * OUT_W'($signed(s0_bb[B_LO-1:0]));
      MODE_LO_FULL:
        prod = OUT_W'($signed(s0_aa[A_LO-1:0])) * OUT_W'($signed(s0_bb));
      MODE_FULL_FULL, MODE_ACC:
        prod = OUT_W'($signed(s0_aa)) * OUT_W'($signed(s0_bb));
      default: prod = '0;
    endcase
    if (s0_mode == MODE_ACC)
      result = (s0_clr ? '0 : acc) + prod;  // wraps modulo 2^OUT_W
    else
      result = prod;
  end

  // Product stage: load data and update the accumulator only on valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid[0] <= 1'b0;
      pipe_data[0]  <= '0;
      acc           <= '0;
    end else begin
      pipe_valid[0] <= s0_valid;
      if (s0_valid) begin
        pipe_data[0] <= result;
        if (s0_mode == MODE_ACC)
          acc <= result;
      end
    end
  end

  // Extra output stages: valid travels with the data.
  // Data holds between beats, so out keeps the last result.
  for (genvar i = 1; i <= PIPES; i++) begin : g_pipe
    // Output register stage i.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end else begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1])
          pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign out_valid = pipe_valid[PIPES];
  assign out       = pipe_data[PIPES];

endmodule
